leiwand_rv32_uart_tx: RTL and testbench

Memory-mapped 8N1 UART transmitter that sits directly downstream of `leiwand_rv32_core` on its native memory bus (`mem_valid`/`mem_ready`/`mem_addr`/`mem_wen`/data), alongside `simple_mem`. It decodes its own address window, buffers bytes in a small FIFO, and serialises them on `tx` with a programmable baud divider. It gives the core a console and debug output path.

---
 rtl/leiwand_rv32_uart_tx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_leiwand_rv32_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_rv32_uart_tx.sv
// leiwand_rv32_uart_tx: memory-mapped 8N1 UART transmitter on the core's native bus.
// Decodes a 16-byte register window, buffers bytes in a small FIFO and
// serialises them LSB first with a programmable baud divider.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-low
//   mem_valid  - bus request, held until mem_ready
//   mem_addr   - byte address
//   mem_wen    - byte write enables (all zero = read)
//   mem_wdata  - write data
//   mem_ready  - one-cycle completion pulse
//   mem_rdata  - read data, valid while mem_ready is high
//   tx         - serial line, idle high
//   irq        - high when FIFO empty and transmitter idle (one cycle lag)
//
// Registers (index = mem_addr[3:2]):
//   0x0 TXDATA  (W)  push wdata[7:0]; drops and sets OVF when full
//   0x4 STATUS  (R)  {OVF, BUSY, EMPTY, FULL}; write wdata[3]=1 clears OVF
//   0x8 BAUDDIV (RW) 16 bits, bit period = BAUDDIV+1 clocks
//   0xC reserved, reads 0, writes ignored
module leiwand_rv32_uart_tx #(
   parameter int unsigned      XLEN            = 32,
   parameter logic [XLEN-1:0]  BASE_ADDR       = XLEN'(32'h1000_0000),
   parameter int unsigned      FIFO_DEPTH      = 4,
   parameter logic [15:0]      CLK_DIV_DEFAULT = 16'd433
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN/8-1:0] mem_wen,
   input  logic [XLEN-1:0]   mem_wdata,
   output logic              mem_ready,
   output logic [XLEN-1:0]   mem_rdata,
   output logic              tx,
   output logic              irq
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [XLEN:0] BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [XLEN:0] LIMIT_EXT = BASE_EXT + (XLEN+1)'(16);

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // ---------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------
   logic [XLEN:0] addr_ext;
   logic          sel;
   logic          accept;
   logic [1:0]    reg_idx;
   logic          is_write;

   assign addr_ext = {1'b0, mem_addr};
   assign sel      = mem_valid && (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
   // Never accept while mem_ready is high so a held request completes once.
   assign accept   = sel && !mem_ready;
   assign reg_idx  = mem_addr[3:2];
   assign is_write = |mem_wen;

   // Bits of the bus that no register consumes.
   logic unused_bits;
   assign unused_bits = ^{mem_wen[XLEN/8-1:2], mem_wdata[XLEN-1:16], mem_addr[1:0]};

   // ---------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push_req;
   logic          push;
   logic          pop;

   assign fifo_empty = (wptr == rptr);
   assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push_req   = accept && (reg_idx == REG_TXDATA) && mem_wen[0];
   // Full is judged on the pre-edge pointers, regardless of a same-edge pop.
   assign push       = push_req && !fifo_full;

   // FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            fifo_mem[wptr[AW-1:0]] <= mem_wdata[7:0];
            wptr                   <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
      end
   end

   // ---------------------------------------------------------------
   // Registers and bus response
   // ---------------------------------------------------------------
   logic [15:0]     bauddiv;
   logic            ovf;
   logic            busy;
   logic            ovf_clr;
   logic [XLEN-1:0] rd_val;
   tx_state_t       state;

   assign busy    = (state != ST_IDLE);
   assign ovf_clr = accept && (reg_idx == REG_STATUS) && mem_wen[0] && mem_wdata[3];

   // Read mux
   always_comb begin
      rd_val = '0;
      if (!is_write) begin
         case (reg_idx)
            REG_STATUS:  rd_val = XLEN'({ovf, busy, fifo_empty, fifo_full});
            REG_BAUDDIV: rd_val = XLEN'(bauddiv);
            default:     rd_val = '0;
         endcase
      end
   end

   // Bus handshake, OVF flag and divider register
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         ovf       <= 1'b0;
         bauddiv   <= CLK_DIV_DEFAULT;
      end else begin
         mem_ready <= accept;
         mem_rdata <= accept ? rd_val : '0;
         // A same-edge overflow wins over the clear.
         if (push_req && fifo_full) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
         if (accept && (reg_idx == REG_BAUDDIV)) begin
            if (mem_wen[0]) bauddiv[7:0]  <= mem_wdata[7:0];
            if (mem_wen[1]) bauddiv[15:8] <= mem_wdata[15:8];
         end
      end
   end

   // ---------------------------------------------------------------
   // TX FSM
   // ---------------------------------------------------------------
   tx_state_t   state_n;
   logic [15:0] cnt;
   logic [15:0] cnt_n;
   logic [15:0] div_q;
   logic [15:0] div_n;
   logic [2:0]  bidx;
   logic [2:0]  bidx_n;
   logic [7:0]  shreg;
   logic [7:0]  shreg_n;
   logic        tx_n;

   // Next state, counters and the registered line level
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      div_n   = div_q;
      bidx_n  = bidx;
      shreg_n = shreg;
      pop     = 1'b0;
      tx_n    = 1'b1;

      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_n = fifo_mem[rptr[AW-1:0]];
               cnt_n   = bauddiv;
               div_n   = bauddiv;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (cnt == 16'd0) begin
               cnt_n   = div_q;
               bidx_n  = 3'd0;
               state_n = ST_DATA;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt == 16'd0) begin
               cnt_n = div_q;
               if (bidx == 3'd7) begin
                  state_n = ST_STOP;
               end else begin
                  bidx_n = bidx + 3'd1;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         ST_STOP: begin
            if (cnt == 16'd0) begin
               // Chain straight into the next frame when data is waiting.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_n = fifo_mem[rptr[AW-1:0]];
                  cnt_n   = bauddiv;
                  div_n   = bauddiv;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      case (state_n)
         ST_START: tx_n = 1'b0;
         ST_DATA:  tx_n = shreg_n[bidx_n];
         default:  tx_n = 1'b1;
      endcase
   end

   // FSM state register, line and interrupt outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         div_q <= '0;
         bidx  <= '0;
         shreg <= '0;
         tx    <= 1'b1;
         irq   <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         div_q <= div_n;
         bidx  <= bidx_n;
         shreg <= shreg_n;
         tx    <= tx_n;
         irq   <= fifo_empty && (state == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_leiwand_rv32_uart_tx.sv
// tb_leiwand_rv32_uart_tx: directed self-checking bench for the UART transmitter.
module tb_leiwand_rv32_uart_tx;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [31:0] A_TX = BASE + 32'h0;
   localparam logic [31:0] A_ST = BASE + 32'h4;
   localparam logic [31:0] A_BD = BASE + 32'h8;
   localparam logic [31:0] A_RS = BASE + 32'hC;

   logic        clk;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wen;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        tx;
   logic        irq;

   int tests;
   int fails;

   leiwand_rv32_uart_tx dut (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wen   (mem_wen),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .tx        (tx),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus transaction; returns just after the edge that raised mem_ready.
   task automatic bus_access(input logic [31:0] addr, input logic [3:0] wen,
                             input logic [31:0] wdata, output logic [31:0] rdata);
      logic got;
      got   = 1'b0;
      rdata = 32'hDEAD_BEEF;
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wen   = wen;
      mem_wdata = wdata;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if (mem_ready === 1'b1) begin
            got   = 1'b1;
            rdata = mem_rdata;
         end
      end
      mem_valid = 1'b0;
      mem_wen   = 4'h0;
      tests++;
      if (got !== 1'b1) begin
         fails++;
         $display("FAIL bus_timeout addr=%h: ready never seen, required within 20 cycles", addr);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      mem_valid = 1'b1;
      mem_addr  = A_BD;
      mem_wen   = 4'h0;
      mem_wdata = 32'h0;
      reset     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({tx, mem_ready, irq} !== 3'b101) begin
         fails++;
         $display("FAIL reset_outputs {tx,ready,irq}=%b required 101", {tx, mem_ready, irq});
      end
      // Request still pending at release is accepted as new.
      reset = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (mem_ready !== 1'b1 || mem_rdata !== 32'd433) begin
         fails++;
         $display("FAIL reset_bauddiv ready=%b rdata=%0d required ready=1 rdata=433", mem_ready, mem_rdata);
      end
      mem_valid = 1'b0;
      begin
         logic [31:0] rd;
         bus_access(A_ST, 4'h0, 32'h0, rd);
         tests++;
         if (rd !== 32'h2) begin
            fails++;
            $display("FAIL reset_status got=%h required 00000002", rd);
         end
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] rd;
      logic [9:0]  exp10;
      logic [39:0] exp40;
      logic [39:0] got40;
      logic        irq_mid;
      bus_access(A_BD, 4'h3, 32'd3, rd);
      // start 0, A5 LSB first = 1,0,1,0,0,1,0,1, stop 1
      exp10 = 10'b1_1010_0101_0;
      for (int i = 0; i < 40; i++) exp40[i] = exp10[i/4];
      bus_access(A_TX, 4'h1, 32'hA5, rd);
      tests++;
      if (tx !== 1'b1) begin
         fails++;
         $display("FAIL frame_pre_start tx=%b required 1", tx);
      end
      irq_mid = 1'bx;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         got40[i] = tx;
         if (i == 20) irq_mid = irq;
      end
      tests++;
      if (got40 !== exp40) begin
         fails++;
         $display("FAIL frame_a5 got=%h required %h", got40, exp40);
      end
      tests++;
      if (irq_mid !== 1'b0) begin
         fails++;
         $display("FAIL frame_irq_busy irq=%b required 0", irq_mid);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (irq !== 1'b1 || tx !== 1'b1) begin
         fails++;
         $display("FAIL frame_end irq=%b tx=%b required 1 1", irq, tx);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [19:0] exp20;
      logic [19:0] got20;
      logic        found;
      bus_access(A_BD, 4'h3, 32'd0, rd);
      // 0x55 frame then 0x0F frame, start/stop included, bit 0 first
      exp20 = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
      got20 = '0;
      found = 1'b0;
      fork
         begin
            bus_access(A_TX, 4'h1, 32'h55, rd);
            bus_access(A_TX, 4'h1, 32'h0F, rd);
         end
         begin
            for (int i = 0; i < 40 && !found; i++) begin
               @(posedge clk); #1;
               if (tx === 1'b0) found = 1'b1;
            end
            if (found) begin
               got20[0] = tx;
               for (int i = 1; i < 20; i++) begin
                  @(posedge clk); #1;
                  got20[i] = tx;
               end
            end
         end
      join
      tests++;
      if (found !== 1'b1) begin
         fails++;
         $display("FAIL b2b_start tx never fell, required within 40 cycles");
      end
      tests++;
      if (got20 !== exp20) begin
         fails++;
         $display("FAIL b2b_frames got=%h required %h", got20, exp20);
      end
      @(posedge clk); #1;
      tests++;
      if (tx !== 1'b1) begin
         fails++;
         $display("FAIL b2b_idle tx=%b required 1", tx);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      bus_access(A_BD, 4'h3, 32'd1000, rd);
      for (int i = 1; i <= 6; i++) bus_access(A_TX, 4'h1, 32'(i), rd);
      bus_access(A_ST, 4'h0, 32'h0, rd);
      tests++;
      if (rd !== 32'h0D) begin
         fails++;
         $display("FAIL ovf_status got=%h required 0000000d", rd);
      end
      bus_access(A_ST, 4'h1, 32'h8, rd);
      bus_access(A_ST, 4'h0, 32'h0, rd);
      tests++;
      if (rd !== 32'h05) begin
         fails++;
         $display("FAIL ovf_clear got=%h required 00000005", rd);
      end
      bus_access(A_BD, 4'h0, 32'h0, rd);
      tests++;
      if (rd !== 32'd1000) begin
         fails++;
         $display("FAIL ovf_bauddiv got=%0d required 1000", rd);
      end
      do_reset();
   endtask

   task automatic test_decode();
      logic [31:0] rd;
      int          seen;
      logic [4:0]  pulses;
      // Outside the window: never answered.
      mem_valid = 1'b1;
      mem_addr  = BASE + 32'h10;
      mem_wen   = 4'h0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (mem_ready !== 1'b0) seen++;
      end
      mem_valid = 1'b0;
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL decode_outside ready pulses=%0d required 0", seen);
      end
      // Reserved slot answers one cycle later with zero data.
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = A_RS;
      @(posedge clk); #1;
      tests++;
      if (mem_ready !== 1'b1 || mem_rdata !== 32'h0) begin
         fails++;
         $display("FAIL decode_reserved ready=%b rdata=%h required 1 00000000", mem_ready, mem_rdata);
      end
      mem_valid = 1'b0;
      bus_access(A_RS, 4'hF, 32'hFFFF_FFFF, rd);
      bus_access(A_BD, 4'h0, 32'h0, rd);
      tests++;
      if (rd !== 32'd433) begin
         fails++;
         $display("FAIL decode_reserved_write bauddiv=%0d required 433", rd);
      end
      // Held request across four edges: ready alternates, then stays low.
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = A_ST;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pulses[i] = mem_ready;
      end
      mem_valid = 1'b0;
      @(posedge clk); #1;
      pulses[4] = mem_ready;
      tests++;
      if (pulses !== 5'b00101) begin
         fails++;
         $display("FAIL decode_held ready pattern=%b required 00101", pulses);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd;
      int          low_seen;
      bus_access(A_BD, 4'h3, 32'd3, rd);
      bus_access(A_TX, 4'h1, 32'h00, rd);
      // Accept edge A is behind us; advance to A+18, inside data bit 3.
      repeat (18) @(posedge clk);
      #1;
      tests++;
      if (tx !== 1'b0) begin
         fails++;
         $display("FAIL midframe_bit3 tx=%b required 0", tx);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (tx !== 1'b1) begin
         fails++;
         $display("FAIL midframe_reset tx=%b required 1", tx);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      low_seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1) low_seen++;
      end
      tests++;
      if (low_seen != 0) begin
         fails++;
         $display("FAIL midframe_residual low cycles=%0d required 0", low_seen);
      end
      bus_access(A_ST, 4'h0, 32'h0, rd);
      tests++;
      if (rd !== 32'h2 || irq !== 1'b1) begin
         fails++;
         $display("FAIL midframe_status status=%h irq=%b required 00000002 1", rd, irq);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      reset     = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = 32'h0;
      mem_wen   = 4'h0;
      mem_wdata = 32'h0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_decode();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
